// File: rtl/supply_seq.sv
// N-rail power sequencer: ascending ramp with per-rail timeout, dropout watch, latched fault.
// SUPPLY_SEQ_REV_OFF_EN selects sequenced top-down shutdown instead of all-at-once.
module supply_seq #(
    parameter int NCH      = 4,
    parameter int RAMP_CYC = 200,
    parameter int OFF_DLY  = 16,
    parameter int CNT_W    = 8,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           EN,
    input  logic           CLR_FAULT,
    input  logic [NCH-1:0] VIN_OK,
    output logic [NCH-1:0] RAIL_EN,
    output logic [NCH-1:0] PG,
    output logic           ALL_PG,
    output logic           FAULT,
    output logic [CHW-1:0] FAULT_CH
);

    if (NCH < 1 || NCH > 16 || RAMP_CYC < 2 || OFF_DLY < 1 ||
        RAMP_CYC > (1 << CNT_W) - 1 ||
        OFF_DLY > (1 << CNT_W) - 1) begin : g_bad_cfg
        $error("supply_seq: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_OFF,
        S_RAMP,
        S_ON,
        S_SHDN,
        S_FLT
    } state_t;

    localparam logic [CHW-1:0]   LAST     = CHW'(NCH - 1);
    localparam logic [CNT_W-1:0] RAMP_MAX = CNT_W'(RAMP_CYC - 1);
`ifdef SUPPLY_SEQ_REV_OFF_EN
    localparam logic [CNT_W-1:0] OFF_MAX  = CNT_W'(OFF_DLY - 1);
`endif

    state_t           state;
    logic [NCH-1:0]   vok_m;
    logic [NCH-1:0]   vok_s;
    logic [CHW-1:0]   idx;
    logic [CNT_W-1:0] cnt;

    logic [NCH-1:0]   drop;
    logic             drop_any;
    logic [CHW-1:0]   drop_ch;
    logic             timeout;
    logic             flt_now;
    logic [CHW-1:0]   idx_up;
`ifdef SUPPLY_SEQ_REV_OFF_EN
    logic [CHW-1:0]   idx_dn;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vok_m <= '0;
            vok_s <= '0;
        end else begin
            vok_m <= VIN_OK;
            vok_s <= vok_m;
        end
    end

    // lowest-index dropout wins the fault channel
    always_comb begin
        drop     = PG & ~vok_s;
        drop_any = |drop;
        drop_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (drop[i]) drop_ch = CHW'(i);
        end
        timeout = (state == S_RAMP) && !vok_s[idx] && (cnt == RAMP_MAX);
        flt_now = drop_any || timeout;
        idx_up  = idx + 1'b1;
`ifdef SUPPLY_SEQ_REV_OFF_EN
        idx_dn  = idx - 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_OFF;
            idx      <= '0;
            cnt      <= '0;
            RAIL_EN  <= '0;
            PG       <= '0;
            ALL_PG   <= 1'b0;
            FAULT    <= 1'b0;
            FAULT_CH <= '0;
        end else begin
            unique case (state)
                S_OFF: begin
                    if (EN) begin
                        state   <= S_RAMP;
                        idx     <= '0;
                        cnt     <= '0;
                        RAIL_EN <= NCH'(1);
                    end
                end
                S_RAMP, S_ON: begin
                    if (flt_now) begin
                        state    <= S_FLT;
                        RAIL_EN  <= '0;
                        PG       <= '0;
                        ALL_PG   <= 1'b0;
                        FAULT    <= 1'b1;
                        FAULT_CH <= drop_any ? drop_ch : idx;
                    end else if (!EN) begin
                        state  <= S_SHDN;
                        ALL_PG <= 1'b0;
`ifdef SUPPLY_SEQ_REV_OFF_EN
                        // idx is always the highest enabled rail here
                        RAIL_EN[idx] <= 1'b0;
                        PG[idx]      <= 1'b0;
                        cnt          <= '0;
`else
                        RAIL_EN <= '0;
                        PG      <= '0;
`endif
                    end else if (state == S_RAMP) begin
                        if (vok_s[idx]) begin
                            PG[idx] <= 1'b1;
                            cnt     <= '0;
                            if (idx == LAST) begin
                                state  <= S_ON;
                                ALL_PG <= 1'b1;
                            end else begin
                                idx             <= idx_up;
                                RAIL_EN[idx_up] <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_SHDN: begin
`ifdef SUPPLY_SEQ_REV_OFF_EN
                    if (cnt == OFF_MAX) begin
                        cnt <= '0;
                        if (idx == '0) begin
                            state <= S_OFF;
                        end else begin
                            idx             <= idx_dn;
                            RAIL_EN[idx_dn] <= 1'b0;
                            PG[idx_dn]      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    state <= S_OFF;
`endif
                end
                S_FLT: begin
                    if (CLR_FAULT && !EN) begin
                        state    <= S_OFF;
                        FAULT    <= 1'b0;
                        FAULT_CH <= '0;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

endmodule
